// File: rtl/pan_frame_serializer_if.sv
// Purpose : frame-in / sample-out bundle for pan_frame_serializer.
// Latency : n/a (wiring only).
// Backpress: frame side and sample side each use their own valid/ready pair.
//
// Signals:
//   i_frame_valid / o_frame_ready : frame handshake (producer -> serializer)
//   i_seq_l / i_seq_r             : N-sample L/R frames, index 0 = oldest
//   o_sample_valid / i_sample_ready : sample handshake (serializer -> consumer)
//   o_sample_l / o_sample_r       : current stereo sample
//   o_sample_last / o_sample_idx  : position of the current sample in its frame
//   o_underrun_cnt                : only with PAN_SERIALIZER_UNDERRUN_CNT_EN
// Modports: slave = serializer side, master = producer/consumer side.
interface pan_frame_serializer_if #(
  parameter int N = 16,
  parameter int W = 16
);
  localparam int IW = $clog2(N);

  logic                  i_frame_valid;
  logic                  o_frame_ready;
  logic [N-1:0][W-1:0]   i_seq_l;
  logic [N-1:0][W-1:0]   i_seq_r;
  logic                  o_sample_valid;
  logic                  i_sample_ready;
  logic [W-1:0]          o_sample_l;
  logic [W-1:0]          o_sample_r;
  logic                  o_sample_last;
  logic [IW-1:0]         o_sample_idx;
`ifdef PAN_SERIALIZER_UNDERRUN_CNT_EN
  logic [7:0]            o_underrun_cnt;
`endif

  modport slave (
    input  i_frame_valid, i_seq_l, i_seq_r, i_sample_ready,
    output o_frame_ready, o_sample_valid, o_sample_l, o_sample_r,
           o_sample_last, o_sample_idx
`ifdef PAN_SERIALIZER_UNDERRUN_CNT_EN
           , o_underrun_cnt
`endif
  );

  modport master (
    output i_frame_valid, i_seq_l, i_seq_r, i_sample_ready,
    input  o_frame_ready, o_sample_valid, o_sample_l, o_sample_r,
           o_sample_last, o_sample_idx
`ifdef PAN_SERIALIZER_UNDERRUN_CNT_EN
           , o_underrun_cnt
`endif
  );
endinterface

// File: rtl/pan_frame_serializer.sv
// Purpose : ping-pong buffers whole N-sample stereo frames and replays them one sample per transfer.
// Latency : frame accepted into an empty buffer shows sample 0 the cycle after the accepting edge.
// Backpress: o_frame_ready drops only when both buffers are full; samples hold while i_sample_ready=0.
//
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : frame input handshake + sample output stream, see pan_frame_serializer_if
// Optional feature: define PAN_SERIALIZER_UNDERRUN_CNT_EN to add bus.o_underrun_cnt, an 8-bit
// saturating count of cycles where the consumer was ready but no sample was available.
module pan_frame_serializer #(
  parameter int N = 16,
  parameter int W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  pan_frame_serializer_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } pair_t;

  state_t        state_q, state_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [IW-1:0] idx_q, idx_d;

  // Frame storage carries no reset: contents are only observed while a frame
  // is buffered, and the outputs are forced to zero otherwise.
  pair_t buf0_q [N];
  pair_t buf1_q [N];

  logic  frame_ready;
  logic  sample_valid;
  logic  accept;
  logic  xfer;
  logic  at_last;
  logic  done;
  pair_t rd_word;

  // Ready and valid come straight from the state register, so neither side's
  // handshake input can ripple combinationally into the other side.
  assign frame_ready  = (state_q != S_FULL);
  assign sample_valid = (state_q != S_EMPTY);

  assign accept  = bus.i_frame_valid & frame_ready;
  assign xfer    = sample_valid & bus.i_sample_ready;
  assign at_last = (idx_q == LAST_IDX);
  assign done    = xfer & at_last;

  // ---------------------------------------------------------------------------
  // Occupancy FSM and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_EMPTY;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    idx_d    = idx_q;

    case (state_q)
      S_EMPTY: begin
        if (accept) state_d = S_ONE;
      end
      S_ONE: begin
        // Accept and finish together leave occupancy unchanged: the new frame
        // lands in the other buffer while the read side flips onto it.
        if (accept && !done)      state_d = S_FULL;
        else if (done && !accept) state_d = S_EMPTY;
      end
      S_FULL: begin
        // No accept is possible here; ready only rises after the state moves.
        if (done) state_d = S_ONE;
      end
      default: state_d = S_EMPTY;
    endcase

    if (accept) wr_sel_d = ~wr_sel_q;

    // idx only moves on a real transfer, so it holds while empty or stalled.
    if (xfer) begin
      if (at_last) begin
        idx_d    = '0;
        rd_sel_d = ~rd_sel_q;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame capture: all N pairs land in the write buffer on the accepting edge.
  // While one frame is buffered, wr_sel differs from rd_sel, so a capture never
  // touches the buffer currently driving the outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        if (wr_sel_q) buf1_q[i] <= '{l: bus.i_seq_l[i], r: bus.i_seq_r[i]};
        else          buf0_q[i] <= '{l: bus.i_seq_l[i], r: bus.i_seq_r[i]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output datapath: pure mux from registers, gated to zero when empty.
  // ---------------------------------------------------------------------------
  assign rd_word = rd_sel_q ? buf1_q[idx_q] : buf0_q[idx_q];

  assign bus.o_frame_ready  = frame_ready;
  assign bus.o_sample_valid = sample_valid;
  assign bus.o_sample_l     = sample_valid ? rd_word.l : '0;
  assign bus.o_sample_r     = sample_valid ? rd_word.r : '0;
  assign bus.o_sample_idx   = idx_q;
  assign bus.o_sample_last  = sample_valid & at_last;

`ifdef PAN_SERIALIZER_UNDERRUN_CNT_EN
  // ---------------------------------------------------------------------------
  // Underrun counter: consumer asked for a sample and none was available.
  // ---------------------------------------------------------------------------
  logic [7:0] urun_q, urun_d;

  always_comb begin
    urun_d = urun_q;
    if (bus.i_sample_ready && !sample_valid && (urun_q != 8'hFF))
      urun_d = urun_q + 8'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) urun_q <= '0;
    else       urun_q <= urun_d;
  end

  assign bus.o_underrun_cnt = urun_q;
`endif

endmodule

// File: tb/tb_pan_frame_serializer.sv
// Purpose : self-checking bench for pan_frame_serializer (table vectors, directed corners, random vs model).
// Latency : drives at negedge, samples 1 time unit later, state advances on posedge.
// Backpress: stimulus toggles both frame_valid and sample_ready; the model tracks occupancy itself.
module tb_pan_frame_serializer;
  localparam int N  = 16;
  localparam int W  = 16;
  localparam int IW = $clog2(N);

  typedef logic [N-1:0][W-1:0] frame_t;
  typedef struct {
    frame_t l;
    frame_t r;
  } mframe_t;

  typedef struct {
    bit          fv;
    int          tag;
    bit          sr;
    bit          e_fr;
    bit          e_sv;
    int          e_idx;
    bit          e_last;
    int          e_l;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pan_frame_serializer_if #(.N(N), .W(W)) bus ();

  pan_frame_serializer #(.N(N), .W(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of whole frames plus a read position.
  mframe_t m_q[$];
  int      m_idx  = 0;
  int      m_urun = 0;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t tag_l(input int tag);
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = W'(tag * 256 + i);
    return f;
  endfunction

  function automatic frame_t tag_r(input int tag);
    return ~tag_l(tag);
  endfunction

  function automatic vec_t mkv(input bit fv, input int tag, input bit sr, input bit fr,
                               input bit sv, input int idx, input bit last, input int l);
    vec_t v;
    v.fv = fv; v.tag = tag; v.sr = sr; v.e_fr = fr; v.e_sv = sv;
    v.e_idx = idx; v.e_last = last; v.e_l = l;
    return v;
  endfunction

  task automatic model_cmp();
    bit          have;
    logic [W-1:0] el, er;
    have = (m_q.size() > 0);
    el = '0;
    er = '0;
    if (have) begin
      el = m_q[0].l[m_idx];
      er = m_q[0].r[m_idx];
    end
    chk("m_frame_ready", 32'(bus.o_frame_ready), 32'(m_q.size() < 2));
    chk("m_sample_valid", 32'(bus.o_sample_valid), 32'(have));
    chk("m_sample_l", 32'(bus.o_sample_l), 32'(el));
    chk("m_sample_r", 32'(bus.o_sample_r), 32'(er));
    chk("m_sample_idx", 32'(bus.o_sample_idx), 32'(m_idx));
    chk("m_sample_last", 32'(bus.o_sample_last), 32'(have && m_idx == N - 1));
`ifdef PAN_SERIALIZER_UNDERRUN_CNT_EN
    chk("m_underrun", 32'(bus.o_underrun_cnt), 32'(m_urun));
`endif
  endtask

  // Apply inputs for one cycle and compare against the model's current state.
  task automatic drive(input bit fv, input frame_t l, input frame_t r, input bit sr);
    @(negedge clk);
    bus.i_frame_valid  = fv;
    bus.i_seq_l        = l;
    bus.i_seq_r        = r;
    bus.i_sample_ready = sr;
    #1;
    model_cmp();
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic tick();
    bit acc, xf;
    mframe_t f;
    acc = bus.i_frame_valid && (m_q.size() < 2);
    xf  = bus.i_sample_ready && (m_q.size() > 0);
    if (bus.i_sample_ready && m_q.size() == 0 && m_urun < 255) m_urun++;
    if (xf) begin
      if (m_idx == N - 1) begin
        void'(m_q.pop_front());
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    if (acc) begin
      f.l = bus.i_seq_l;
      f.r = bus.i_seq_r;
      m_q.push_back(f);
    end
    @(posedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    m_q.delete();
    m_idx  = 0;
    m_urun = 0;
    chk("rst_sample_valid", 32'(bus.o_sample_valid), 32'd0);
    chk("rst_frame_ready", 32'(bus.o_frame_ready), 32'd1);
    chk("rst_sample_idx", 32'(bus.o_sample_idx), 32'd0);
    chk("rst_sample_last", 32'(bus.o_sample_last), 32'd0);
    chk("rst_sample_l", 32'(bus.o_sample_l), 32'd0);
    chk("rst_sample_r", 32'(bus.o_sample_r), 32'd0);
`ifdef PAN_SERIALIZER_UNDERRUN_CNT_EN
    chk("rst_underrun", 32'(bus.o_underrun_cnt), 32'd0);
`endif
    #2;
    rst = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    frame_t fl, fr;

    bus.i_frame_valid  = 1'b0;
    bus.i_seq_l        = '0;
    bus.i_seq_r        = '0;
    bus.i_sample_ready = 1'b0;

    // ---- vector table: fill / held-off frame / stall / back-to-back ----
    vt.push_back(mkv(1, 1, 0, 1, 0, 0, 0, 0));          // A offered into empty
    vt.push_back(mkv(1, 2, 0, 1, 1, 0, 0, 16'h0100));   // B offered, A visible
    vt.push_back(mkv(1, 3, 0, 0, 1, 0, 0, 16'h0100));   // full: C held off
    vt.push_back(mkv(1, 3, 0, 0, 1, 0, 0, 16'h0100));
    for (int i = 0; i < N; i++)                          // drain A, C still held
      vt.push_back(mkv(1, 3, 1, 0, 1, i, i == N - 1, 16'h0100 + i));
    vt.push_back(mkv(1, 3, 0, 1, 1, 0, 0, 16'h0200));   // ready rises, C taken
    vt.push_back(mkv(0, 0, 0, 0, 1, 0, 0, 16'h0200));
    for (int i = 0; i < N; i++)                          // drain B
      vt.push_back(mkv(0, 0, 1, 0, 1, i, i == N - 1, 16'h0200 + i));
    for (int i = 0; i < 7; i++)                          // C up to idx 7
      vt.push_back(mkv(0, 0, 1, 1, 1, i, 0, 16'h0300 + i));
    vt.push_back(mkv(1, 4, 0, 1, 1, 7, 0, 16'h0307));   // stall + accept D
    for (int i = 0; i < 3; i++)
      vt.push_back(mkv(0, 0, 0, 0, 1, 7, 0, 16'h0307));
    for (int i = 7; i < N; i++)                          // resume at 7
      vt.push_back(mkv(0, 0, 1, 0, 1, i, i == N - 1, 16'h0300 + i));
    for (int i = 0; i < N - 1; i++)                      // D in ONE
      vt.push_back(mkv(0, 0, 1, 1, 1, i, 0, 16'h0400 + i));
    vt.push_back(mkv(1, 5, 1, 1, 1, 15, 1, 16'h040F));  // accept E on D's last
    for (int i = 0; i < N; i++)                          // E with no bubble
      vt.push_back(mkv(0, 0, 1, 1, 1, i, i == N - 1, 16'h0500 + i));
    vt.push_back(mkv(0, 0, 1, 1, 0, 0, 0, 0));          // empty again

    repeat (3) @(posedge clk);
    #2;
    pulse_reset();

    foreach (vt[k]) begin
      drive(vt[k].fv, tag_l(vt[k].tag), tag_r(vt[k].tag), vt[k].sr);
      chk($sformatf("vec%0d_frame_ready", k), 32'(bus.o_frame_ready), 32'(vt[k].e_fr));
      chk($sformatf("vec%0d_sample_valid", k), 32'(bus.o_sample_valid), 32'(vt[k].e_sv));
      chk($sformatf("vec%0d_sample_idx", k), 32'(bus.o_sample_idx), 32'(vt[k].e_idx));
      chk($sformatf("vec%0d_sample_last", k), 32'(bus.o_sample_last), 32'(vt[k].e_last));
      chk($sformatf("vec%0d_sample_l", k), 32'(bus.o_sample_l), 32'(vt[k].e_l));
      tick();
    end

    // ---- single frame with ready held high ----
    for (int i = 0; i < N; i++) begin
      fl[i] = W'(i);
      fr[i] = W'(16'h8000 + i);
    end
    drive(1, fl, fr, 1);
    tick();
    for (int i = 0; i < N; i++) begin
      drive(0, '0, '0, 1);
      chk($sformatf("single_l%0d", i), 32'(bus.o_sample_l), 32'(i));
      chk($sformatf("single_r%0d", i), 32'(bus.o_sample_r), 32'(16'h8000 + i));
      chk($sformatf("single_last%0d", i), 32'(bus.o_sample_last), 32'(i == N - 1));
      tick();
    end
    drive(0, '0, '0, 1);
    chk("single_after_valid", 32'(bus.o_sample_valid), 32'd0);
    tick();

    // ---- reset mid-stream ----
    for (int i = 0; i < N; i++) fl[i] = W'(16'h2000 + i);
    drive(1, fl, ~fl, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, '0, '0, 1);
      tick();
    end
    drive(0, '0, '0, 0);
    chk("midrst_idx_before", 32'(bus.o_sample_idx), 32'd5);
    pulse_reset();
    for (int i = 0; i < N; i++) fl[i] = W'(16'h1000 + i);
    drive(1, fl, ~fl, 1);
    tick();
    for (int i = 0; i < N; i++) begin
      drive(0, '0, '0, 1);
      chk($sformatf("postrst_l%0d", i), 32'(bus.o_sample_l), 32'(16'h1000 + i));
      tick();
    end

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        fl[i] = W'($urandom);
        fr[i] = W'($urandom);
      end
      drive($urandom_range(0, 2) == 0, fl, fr, $urandom_range(0, 3) != 0);
      tick();
    end
    for (int c = 0; c < 2 * N + 2; c++) begin
      drive(0, '0, '0, 1);
      tick();
    end

`ifdef PAN_SERIALIZER_UNDERRUN_CNT_EN
    // ---- underrun counter saturation ----
    pulse_reset();
    for (int c = 0; c < 300; c++) begin
      drive(0, '0, '0, 1);
      tick();
    end
    drive(0, '0, '0, 1);
    chk("urun_sat", 32'(bus.o_underrun_cnt), 32'd255);
    tick();
    drive(1, tag_l(9), tag_r(9), 1);
    tick();
    for (int i = 0; i < N; i++) begin
      drive(0, '0, '0, 1);
      tick();
    end
    drive(0, '0, '0, 0);
    chk("urun_after_frame", 32'(bus.o_underrun_cnt), 32'd255);
    pulse_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
